// File: rtl/axi_read_arbiter_rr.sv
// Round-robin AXI read-channel arbiter: grants one master the AR/R path, decodes
// the winner's ARADDR to a slave index and checks the R burst against ARLEN.
module axi_read_arbiter_rr #(
    parameter  int NUM_M  = 2,
    parameter  int ADDR_W = 32,
    parameter  int LEN_W  = 4,
    localparam int IDX_W  = $clog2(NUM_M)
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [NUM_M-1:0]        ARVALID,
    input  logic [NUM_M*ADDR_W-1:0] ARADDR,
    input  logic [NUM_M*LEN_W-1:0]  ARLEN,
    input  logic                    ARREADY,
    input  logic                    RVALID,
    input  logic                    RREADY,
    input  logic                    RLAST,
    output logic [NUM_M-1:0]        grant_oh,
    output logic [IDX_W-1:0]        grant_idx,
    output logic [2:0]              slave_sel,
    output logic [IDX_W+2:0]        arid_ctrl,
    output logic                    busy,
    output logic [LEN_W:0]          beat_cnt,
    output logic                    len_err
);

    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_M-1:0]   grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [2:0]         slave_sel_q, slave_sel_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               len_err_q, len_err_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic [IDX_W-1:0]   win_idx_s;
    logic [ADDR_W-1:0]  win_addr_s;
    logic [LEN_W-1:0]   gnt_len_s;
    logic               gnt_arvalid_s;
    logic               any_req_s;
    logic               ar_hs_s;
    logic               r_hs_s;
    logic               len_hit_s;

    // Address map; only bits [31:10] take part in the decode.
    function automatic logic [2:0] decode_slave(input logic [ADDR_W-1:0] addr);
        logic [2:0] sel;
        if (addr[31:16] == 16'h0000) begin
            sel = 3'd0;
        end else if (addr[31:16] == 16'h0001) begin
            sel = 3'd1;
        end else if (addr[31:16] == 16'h0002) begin
            sel = 3'd2;
        end else if (addr[31:10] == 22'h04_0000) begin
            sel = 3'd3;
        end else if (addr[31:21] == 11'h100) begin
            sel = 3'd4;
        end else begin
            sel = 3'd5;
        end
        return sel;
    endfunction

    // First requester found walking up from ptr with wrap-around at NUM_M.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        cand  = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
            cand = (cand == IDX_W'(NUM_M - 1)) ? {IDX_W{1'b0}} : cand + IDX_W'(1);
        end
        return pick;
    endfunction

    // Per-master fields of the arbitration winner and of the current grant holder.
    always_comb begin
        win_idx_s     = rr_pick(ARVALID, rr_ptr_q);
        win_addr_s    = {ADDR_W{1'b0}};
        gnt_len_s     = {LEN_W{1'b0}};
        gnt_arvalid_s = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            win_addr_s    = (win_idx_s == IDX_W'(i))   ? ARADDR[i*ADDR_W +: ADDR_W] : win_addr_s;
            gnt_len_s     = (grant_idx_q == IDX_W'(i)) ? ARLEN[i*LEN_W +: LEN_W]    : gnt_len_s;
            gnt_arvalid_s = (grant_idx_q == IDX_W'(i)) ? ARVALID[i]                 : gnt_arvalid_s;
        end
    end

    assign any_req_s = |ARVALID;
    assign ar_hs_s   = gnt_arvalid_s && ARREADY;
    assign r_hs_s    = RVALID && RREADY;
    assign len_hit_s = (beat_cnt_q == {1'b0, len_q});

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = any_req_s ? S_ADDR : S_IDLE;
            S_ADDR:  state_d = ar_hs_s ? S_DATA : S_ADDR;
            S_DATA:  state_d = (r_hs_s && RLAST) ? S_IDLE : S_DATA;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant, decode and beat accounting updates for each state.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_oh_d  = grant_oh_q;
        grant_idx_d = grant_idx_q;
        slave_sel_d = slave_sel_q;
        busy_d      = busy_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        len_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    grant_oh_d  = NUM_M'(1) << win_idx_s;
                    grant_idx_d = win_idx_s;
                    slave_sel_d = decode_slave(win_addr_s);
                    busy_d      = 1'b1;
                end else begin
                    grant_oh_d  = {NUM_M{1'b0}};
                    busy_d      = 1'b0;
                end
            end
            S_ADDR: begin
                if (ar_hs_s) begin
                    len_d      = gnt_len_s;
                    beat_cnt_d = {CNT_W{1'b0}};
                end else begin
                    len_d      = len_q;
                end
            end
            S_DATA: begin
                if (r_hs_s) begin
                    beat_cnt_d = (beat_cnt_q == {CNT_W{1'b1}}) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
                    // beat_cnt still holds the count before this beat.
                    if (RLAST) begin
                        len_err_d  = !len_hit_s;
                        grant_oh_d = {NUM_M{1'b0}};
                        busy_d     = 1'b0;
                        rr_ptr_d   = (grant_idx_q == IDX_W'(NUM_M - 1)) ? {IDX_W{1'b0}}
                                                                        : grant_idx_q + IDX_W'(1);
                    end else begin
                        len_err_d  = len_hit_s;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                grant_oh_d = {NUM_M{1'b0}};
                busy_d     = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_ptr_q    <= {IDX_W{1'b0}};
            grant_oh_q  <= {NUM_M{1'b0}};
            grant_idx_q <= {IDX_W{1'b0}};
            slave_sel_q <= 3'd0;
            busy_q      <= 1'b0;
            beat_cnt_q  <= {CNT_W{1'b0}};
            len_err_q   <= 1'b0;
            len_q       <= {LEN_W{1'b0}};
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            slave_sel_q <= slave_sel_d;
            busy_q      <= busy_d;
            beat_cnt_q  <= beat_cnt_d;
            len_err_q   <= len_err_d;
            len_q       <= len_d;
        end
    end

    assign grant_oh  = grant_oh_q;
    assign grant_idx = grant_idx_q;
    assign slave_sel = slave_sel_q;
    assign arid_ctrl = {grant_idx_q, slave_sel_q};
    assign busy      = busy_q;
    assign beat_cnt  = beat_cnt_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// Self-checking bench for axi_read_arbiter_rr with four masters: per-cycle vector
// table run through an expected-value queue, plus a mid-burst reset sequence.
module tb_axi_read_arbiter_rr;

    logic         ACLK;
    logic         ARESETn;
    logic [3:0]   arvalid;
    logic [127:0] araddr;
    logic [15:0]  arlen;
    logic         arready, rvalid, rready, rlast;
    logic [3:0]   grant_oh;
    logic [1:0]   grant_idx;
    logic [2:0]   slave_sel;
    logic [4:0]   arid_ctrl;
    logic         busy;
    logic [4:0]   beat_cnt;
    logic         len_err;
    logic [20:0]  act_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [3:0] arv;
        logic [31:0] addr;
        logic [3:0] len;
        logic       ardy, rv, rr, rl;
        logic [3:0] goh;
        logic [1:0] gidx;
        logic [2:0] sel;
        logic       busy;
        logic [4:0] cnt;
        logic       err;
    } vec_t;

    vec_t        tbl[$];
    logic [20:0] exp_q[$];
    string       name_q[$];

    axi_read_arbiter_rr #(.NUM_M(4), .ADDR_W(32), .LEN_W(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARVALID(arvalid), .ARADDR(araddr), .ARLEN(arlen),
        .ARREADY(arready), .RVALID(rvalid), .RREADY(rready), .RLAST(rlast),
        .grant_oh(grant_oh), .grant_idx(grant_idx), .slave_sel(slave_sel),
        .arid_ctrl(arid_ctrl), .busy(busy), .beat_cnt(beat_cnt), .len_err(len_err)
    );

    assign act_s = {grant_oh, grant_idx, slave_sel, arid_ctrl, busy, beat_cnt, len_err};

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string nm, input logic [3:0] arv, input logic [31:0] addr,
                                input logic [3:0] len, input logic ardy, input logic rv,
                                input logic rr, input logic rl, input logic [3:0] goh,
                                input logic [1:0] gidx, input logic [2:0] sel, input logic bsy,
                                input logic [4:0] cnt, input logic err);
        vec_t v;
        v.name = nm; v.arv = arv; v.addr = addr; v.len = len;
        v.ardy = ardy; v.rv = rv; v.rr = rr; v.rl = rl;
        v.goh = goh; v.gidx = gidx; v.sel = sel; v.busy = bsy; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    function automatic logic [20:0] pack_exp(input vec_t v);
        return {v.goh, v.gidx, v.sel, v.gidx, v.sel, v.busy, v.cnt, v.err};
    endfunction

    // Grant cycle, AR handshake, then nbeats R beats with RLAST on the last one.
    task automatic add_burst(input string nm, input logic [3:0] arv, input logic [31:0] addr,
                             input logic [3:0] len, input logic [3:0] goh, input logic [1:0] gidx,
                             input logic [2:0] sel, input logic [4:0] prev_cnt, input int nbeats);
        logic rl;
        logic err;
        tbl.push_back(mk({nm, "_grant"}, arv, addr, len, 1'b0, 1'b0, 1'b0, 1'b0,
                         goh, gidx, sel, 1'b1, prev_cnt, 1'b0));
        tbl.push_back(mk({nm, "_ar"}, arv, addr, len, 1'b1, 1'b0, 1'b0, 1'b0,
                         goh, gidx, sel, 1'b1, 5'd0, 1'b0));
        for (int k = 1; k <= nbeats; k++) begin
            rl  = (k == nbeats);
            err = rl ? (5'(k - 1) != {1'b0, len}) : (5'(k - 1) == {1'b0, len});
            tbl.push_back(mk($sformatf("%s_beat%0d", nm, k), arv, addr, len, 1'b0, 1'b1, 1'b1, rl,
                             rl ? 4'b0000 : goh, gidx, sel, !rl, 5'(k), err));
        end
    endtask

    // Masters without ARVALID carry a default-slave address so a wrong address mux shows up.
    task automatic drive(input vec_t v);
        arvalid = v.arv;
        for (int m = 0; m < 4; m++) begin
            araddr[m*32 +: 32] = v.arv[m] ? v.addr : 32'hFFFF_FFF0;
            arlen[m*4 +: 4]    = v.len;
        end
        arready = v.ardy;
        rvalid  = v.rv;
        rready  = v.rr;
        rlast   = v.rl;
    endtask

    task automatic check_val(input string nm, input logic [20:0] got, input logic [20:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got {goh,gidx,sel,arid,busy,cnt,err}=%b_%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b_%b",
                     nm, got[20:17], got[16:15], got[14:12], got[11:7], got[6], got[5:1], got[0],
                     want[20:17], want[16:15], want[14:12], want[11:7], want[6], want[5:1], want[0]);
        end
    endtask

    task automatic check_out();
        logic [20:0] e;
        string       nm;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got %h expected a queued value", act_s);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check_val(nm, act_s, e);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge ACLK);
        drive(v);
        exp_q.push_back(pack_exp(v));
        name_q.push_back(v.name);
        @(posedge ACLK);
        #1;
        check_out();
    endtask

    initial begin
        ARESETn = 1'b0;
        drive(mk("init", 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                 4'b0000, 2'd0, 3'd0, 1'b0, 5'd0, 1'b0));

        // M0/M1 alternate on 4-beat DRAM bursts.
        add_burst("dram_m0a", 4'b0011, 32'h2000_0000, 4'd3, 4'b0001, 2'd0, 3'd4, 5'd0, 4);
        add_burst("dram_m1a", 4'b0011, 32'h2000_0000, 4'd3, 4'b0010, 2'd1, 3'd4, 5'd4, 4);
        add_burst("dram_m0b", 4'b0011, 32'h2000_0000, 4'd3, 4'b0001, 2'd0, 3'd4, 5'd4, 4);
        add_burst("dram_m1b", 4'b0011, 32'h2000_0000, 4'd3, 4'b0010, 2'd1, 3'd4, 5'd4, 4);
        // Pointer now at 2: M3 wins over M0, then M0; also the sensor/default boundary.
        add_burst("rr_m3_sensor", 4'b1001, 32'h1000_03FC, 4'd0, 4'b1000, 2'd3, 3'd3, 5'd4, 1);
        add_burst("rr_m0_default", 4'b1001, 32'h1000_0400, 4'd0, 4'b0001, 2'd0, 3'd5, 5'd1, 1);
        // Single beat to DM with ARREADY two cycles late and an RREADY stall.
        tbl.push_back(mk("dm_req",   4'b0001, 32'h0002_0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 3'd2, 1'b1, 5'd1, 1'b0));
        tbl.push_back(mk("dm_wait",  4'b0001, 32'h0002_0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 3'd2, 1'b1, 5'd1, 1'b0));
        tbl.push_back(mk("dm_ar",    4'b0001, 32'h0002_0010, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 3'd2, 1'b1, 5'd0, 1'b0));
        tbl.push_back(mk("dm_stall", 4'b0000, 32'h0002_0010, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 3'd2, 1'b1, 5'd0, 1'b0));
        tbl.push_back(mk("dm_beat",  4'b0000, 32'h0002_0010, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 3'd2, 1'b0, 5'd1, 1'b0));
        // Early RLAST (ARLEN=3, last on beat 2), then a one-cycle-pulse check.
        add_burst("early_last", 4'b0100, 32'h0000_0100, 4'd3, 4'b0100, 2'd2, 3'd0, 5'd1, 2);
        tbl.push_back(mk("early_idle", 4'b0000, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 3'd0, 1'b0, 5'd2, 1'b0));
        // Overrun (ARLEN=1, RLAST on beat 3): flagged at beat 2 and again at the late RLAST.
        add_burst("overrun", 4'b0010, 32'h0001_0000, 4'd1, 4'b0010, 2'd1, 3'd1, 5'd2, 3);
        tbl.push_back(mk("overrun_idle", 4'b0000, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 3'd1, 1'b0, 5'd3, 1'b0));

        #12;
        check_val("reset_state", act_s, 21'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i]);
        end

        // Reset in the middle of a 4-beat burst, then re-arbitration from pointer 0.
        step(mk("mid_grant", 4'b0001, 32'h2000_0000, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 3'd4, 1'b1, 5'd3, 1'b0));
        step(mk("mid_ar",    4'b0001, 32'h2000_0000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 3'd4, 1'b1, 5'd0, 1'b0));
        step(mk("mid_beat1", 4'b0000, 32'h2000_0000, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 3'd4, 1'b1, 5'd1, 1'b0));
        step(mk("mid_beat2", 4'b0000, 32'h2000_0000, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 3'd4, 1'b1, 5'd2, 1'b0));
        @(negedge ACLK);
        #2;
        ARESETn = 1'b0;
        #1;
        check_val("async_reset_mid_burst", act_s, 21'd0);
        @(posedge ACLK);
        #1;
        check_val("reset_held", act_s, 21'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        drive(mk("post_idle", 4'b0000, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 3'd0, 1'b0, 5'd0, 1'b0));
        step(mk("post_grant_m1", 4'b1010, 32'h0001_0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 3'd1, 1'b1, 5'd0, 1'b0));
        step(mk("post_ar",       4'b1010, 32'h0001_0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1, 3'd1, 1'b1, 5'd0, 1'b0));
        step(mk("post_beat",     4'b1010, 32'h0001_0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd1, 3'd1, 1'b0, 5'd1, 1'b0));
        step(mk("post_grant_m3", 4'b1000, 32'h0001_0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3, 3'd1, 1'b1, 5'd1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
